// File: rtl/rf_output_ramp.sv
// rf_output_ramp: RF envelope ramp FSM with watchdog kill and one-clock gain datapath.
// Optional macro RF_WARN_ATTEN_EN halves the applied gain while wd_warning is high.
module rf_output_ramp #(
    parameter int DATA_W    = 14,
    parameter int RAMP_STEP = 16,
    parameter int RAMP_DIV  = 125
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     broadcast_en,
    input  logic                     wd_triggered,
    input  logic                     wd_warning,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_out_valid,
    output logic [15:0]              gain,
    output logic [2:0]               state,
    output logic                     rf_active,
    output logic                     killed
);
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_UP     = 3'd1,
        S_ON     = 3'd2,
        S_DOWN   = 3'd3,
        S_KILLED = 3'd4
    } state_t;

    localparam int          PW    = $clog2(RAMP_DIV + 1);
    localparam logic [15:0] UNITY = 16'h8000;
    localparam logic [16:0] STEP  = 17'(RAMP_STEP);

    state_t                   r_state, w_state_nx;
    logic [15:0]              r_gain, w_gain_nx, w_gain_tick, w_eff;
    logic [PW-1:0]            r_presc, w_presc_nx;
    logic                     r_kill, w_kill_nx;
    logic                     w_ramping, w_tick;
    logic [16:0]              w_up_sum;
    logic signed [DATA_W+16:0] w_prod;
    logic signed [DATA_W-1:0] r_out;
    logic                     r_out_valid;

    assign w_ramping   = (r_state == S_UP) || (r_state == S_DOWN);
    assign w_tick      = w_ramping && (r_presc == PW'(RAMP_DIV - 1));
    assign w_up_sum    = {1'b0, r_gain} + STEP;
    assign w_gain_tick = (r_state == S_UP)
                       ? ((w_up_sum >= {1'b0, UNITY}) ? UNITY : w_up_sum[15:0])
                       : (({1'b0, r_gain} <= STEP) ? 16'd0 : r_gain - STEP[15:0]);

    // The tick is applied first; transitions below look at the post-tick gain.
    always_comb begin
        w_state_nx = r_state;
        w_kill_nx  = r_kill;
        w_gain_nx  = w_tick ? w_gain_tick : r_gain;
        case (r_state)
            S_OFF: begin
                w_gain_nx = '0;
                if (broadcast_en && !wd_triggered) w_state_nx = S_UP;
            end
            S_UP: begin
                if (wd_triggered) begin
                    w_state_nx = S_DOWN;
                    w_kill_nx  = 1'b1;
                end else if (!broadcast_en) w_state_nx = S_DOWN;
                else if (w_gain_nx == UNITY) w_state_nx = S_ON;
            end
            S_ON: begin
                w_gain_nx = UNITY;
                if (wd_triggered) begin
                    w_state_nx = S_DOWN;
                    w_kill_nx  = 1'b1;
                end else if (!broadcast_en) w_state_nx = S_DOWN;
            end
            S_DOWN: begin
                if (wd_triggered) w_kill_nx = 1'b1;
                if (!w_kill_nx && broadcast_en) w_state_nx = S_UP;
                else if (w_gain_nx == 16'd0) w_state_nx = w_kill_nx ? S_KILLED : S_OFF;
            end
            S_KILLED: begin
                w_gain_nx = '0;
                if (!broadcast_en && !wd_triggered) begin
                    w_state_nx = S_OFF;
                    w_kill_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_OFF;
                w_gain_nx  = '0;
                w_kill_nx  = 1'b0;
            end
        endcase
        w_presc_nx = (w_state_nx != r_state || !w_ramping || w_tick) ? '0 : r_presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_gain  <= '0;
            r_kill  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gain  <= w_gain_nx;
            r_kill  <= w_kill_nx;
            r_presc <= w_presc_nx;
        end
    end

`ifdef RF_WARN_ATTEN_EN
    assign w_eff = wd_warning ? (r_gain >> 1) : r_gain;
`else
    logic w_unused_warning;
    assign w_unused_warning = wd_warning;
    assign w_eff = r_gain;
`endif

    assign w_prod = sample_in * $signed({1'b0, w_eff});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= sample_valid;
            if (sample_valid) r_out <= w_prod[DATA_W+14:15];
        end
    end

    assign sample_out       = r_out;
    assign sample_out_valid = r_out_valid;
    assign gain             = r_gain;
    assign state            = r_state;
    assign rf_active        = (r_gain != 16'd0);
    assign killed           = (r_state == S_KILLED);
endmodule

// File: tb/tb_rf_output_ramp.sv
// tb_rf_output_ramp: directed scenarios with a sample scoreboard for rf_output_ramp.
module tb_rf_output_ramp;
    logic               clk = 1'b0;
    logic               rst, broadcast_en, wd_triggered, wd_warning, sample_valid;
    logic signed [13:0] sample_in, sample_out;
    logic               sample_out_valid, rf_active, killed;
    logic [15:0]        gain;
    logic [2:0]         state;

    int                 n_chk = 0;
    int                 n_fail = 0;
    logic signed [13:0] q[$];

`ifdef RF_WARN_ATTEN_EN
    localparam int WARN_OUT = 500;
`else
    localparam int WARN_OUT = 1000;
`endif

    rf_output_ramp #(.DATA_W(14), .RAMP_STEP(8192), .RAMP_DIV(2)) dut (
        .clk(clk), .rst(rst), .broadcast_en(broadcast_en), .wd_triggered(wd_triggered),
        .wd_warning(wd_warning), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid), .gain(gain),
        .state(state), .rf_active(rf_active), .killed(killed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [13:0] exp_out(input int s, input int g, input logic warn);
        int e;
        e = g;
`ifdef RF_WARN_ATTEN_EN
        if (warn) e = g >> 1;
`endif
        return 14'((s * e) >>> 15);
    endfunction

    // Check registered state before the edge, then score the sample the edge produces.
    task automatic tick(input int eg, input int es);
        logic pushed;
        @(negedge clk);
        check("gain", gain, eg);
        check("state", state, es);
        check("rf_active", rf_active, eg != 0);
        check("killed", killed, es == 4);
        pushed = sample_valid;
        if (sample_valid) q.push_back(exp_out(sample_in, eg, wd_warning));
        @(posedge clk);
        #1;
        check("out_valid", sample_out_valid, pushed);
        if (q.size() != 0) check("sample_out", sample_out, q.pop_front());
    endtask

    task automatic ramp_up();
        tick(0, 0);
        for (int k = 0; k < 4; k++) repeat (2) tick(k * 8192, 1);
    endtask

    initial begin
        rst = 1'b1; broadcast_en = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0;
        sample_in = 14'sd1000; sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gain", gain, 0);
        check("rst_state", state, 0);
        check("rst_valid", sample_out_valid, 0);
        check("rst_out", sample_out, 0);
        check("rst_active", rf_active, 0);
        check("rst_killed", killed, 0);
        rst = 1'b0; broadcast_en = 1'b1; sample_valid = 1'b1;
        ramp_up();
        tick(32768, 2);
        // watchdog kill pulse while ON, broadcast_en kept high
        wd_triggered = 1'b1;
        tick(32768, 2);
        wd_triggered = 1'b0;
        for (int k = 4; k > 0; k--) repeat (2) tick(k * 8192, 3);
        repeat (3) tick(0, 4);
        broadcast_en = 1'b0; wd_triggered = 1'b1;
        tick(0, 4);
        wd_triggered = 1'b0;
        tick(0, 4);
        tick(0, 0);
        // simultaneous request and kill in OFF, most negative sample at gain 0
        sample_in = -14'sd8192; broadcast_en = 1'b1; wd_triggered = 1'b1;
        repeat (2) tick(0, 0);
        wd_triggered = 1'b0;
        ramp_up();
        tick(32768, 2);
        // reversal: drop at 16384, reassert after one tick
        sample_in = 14'sd1000; broadcast_en = 1'b0;
        tick(32768, 2);
        for (int k = 4; k > 0; k--) repeat (2) tick(k * 8192, 3);
        broadcast_en = 1'b1;
        tick(0, 0);
        repeat (2) tick(0, 1);
        repeat (2) tick(8192, 1);
        broadcast_en = 1'b0;
        tick(16384, 1);
        repeat (2) tick(16384, 3);
        broadcast_en = 1'b1;
        tick(8192, 3);
        for (int k = 1; k < 4; k++) repeat (2) tick(k * 8192, 1);
        tick(32768, 2);
        // reset mid ramp-down at 16384
        broadcast_en = 1'b0;
        tick(32768, 2);
        repeat (2) tick(32768, 3);
        repeat (2) tick(24576, 3);
        @(negedge clk);
        check("pre_rst_gain", gain, 16384);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_gain", gain, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_valid", sample_out_valid, 0);
        rst = 1'b0; broadcast_en = 1'b1;
        ramp_up();
        tick(32768, 2);
        wd_warning = 1'b1;
        repeat (2) tick(32768, 2);
        check("warn_out", sample_out, WARN_OUT);
        wd_warning = 1'b0; sample_valid = 1'b0; sample_in = 14'sd77;
        tick(32768, 2);
        check("hold_out", sample_out, WARN_OUT);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
